// File: rtl/tilt_filter.sv
// rtl/tilt_filter.sv - accelerometer X-tilt resync, decimation, window averaging and hysteresis
//
// Purpose:
//    Brings the raw accelerometer word into the clk domain, samples it once
//    every SAMPLE_DIV cycles, averages the signed X tilt over 2^AVG_LOG2
//    samples and turns the average into hysteretic left/right flags plus a
//    saturated 4-bit intensity.
//
// Ports:
//    clk            in   system clock
//    rst            in   asynchronous active-low reset
//    acl_data       in   raw accelerometer word (foreign domain), X tilt in [9:5]
//    tilt_left      out  filtered left flag
//    tilt_right     out  filtered right flag (negative X)
//    tilt_intensity out  |avg| saturated to 15
//    sample_valid   out  one-cycle pulse when the outputs update

module tilt_filter #(
   parameter int SAMPLE_DIV = 100000,
   parameter int AVG_LOG2   = 3,
   parameter int ON_TH      = 4,
   parameter int OFF_TH     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [14:0] acl_data,
   output logic        tilt_left,
   output logic        tilt_right,
   output logic [3:0]  tilt_intensity,
   output logic        sample_valid
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int ACC_W = 5 + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic signed [4:0] ON_POS   = 5'(ON_TH);
   localparam logic signed [4:0] ON_NEG   = 5'(-ON_TH);
   localparam logic signed [4:0] OFF_POS  = 5'(OFF_TH);
   localparam logic signed [4:0] OFF_NEG  = 5'(-OFF_TH);

   typedef enum logic {FILL, RUN} state_e;

   // Input resynchronisation
   logic [14:0] s1_q, s2_q, s3_q, held_q;

   // Only the X field is consumed; the whole word still gates `held` so a
   // skewed multi-bit update is never captured half-way.
   logic unused_bits;
   assign unused_bits = ^{held_q[14:10], held_q[4:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q   <= '0;
         s2_q   <= '0;
         s3_q   <= '0;
         held_q <= '0;
      end else begin
         s1_q <= acl_data;
         s2_q <= s1_q;
         s3_q <= s2_q;
         if (s2_q == s3_q) begin
            held_q <= s2_q;
         end
      end
   end

   // Sample tick divider
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;

   assign tick  = (div_q == DIV_LAST);
   assign div_d = tick ? '0 : div_q + 1'b1;

   // Window accumulator
   logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum, acc_shr;
   logic        [CNT_W-1:0] cnt_q, cnt_d;
   logic signed [4:0]       smp;
   logic signed [4:0]       avg;
   logic                    win_done;

   assign smp      = held_q[9:5];
   assign acc_sum  = acc_q + ACC_W'(smp);
   assign win_done = tick && (cnt_q == CNT_LAST);
   // Arithmetic shift floors toward -inf; the result always fits in 5 bits.
   assign acc_shr  = acc_sum >>> AVG_LOG2;
   assign avg      = acc_shr[4:0];

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (win_done) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (tick) begin
         acc_d = acc_sum;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         div_q <= div_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   // Hysteresis and intensity for the window being closed
   logic       left_q, left_d, right_q, right_d, valid_q, valid_d;
   logic [3:0] int_q, int_d;
   logic       new_left, new_right;
   logic [3:0] new_int;
   logic [4:0] avg_u, mag;

   assign avg_u = avg;
   // |-16| = 16 shows up as mag[4]; that is the only case needing saturation.
   assign mag     = avg_u[4] ? (~avg_u + 5'd1) : avg_u;
   assign new_int = mag[4] ? 4'd15 : mag[3:0];

   always_comb begin
      new_left = left_q;
      if (avg >= ON_POS) begin
         new_left = 1'b1;
      end else if (avg < OFF_POS) begin
         new_left = 1'b0;
      end
      new_right = right_q;
      if (avg <= ON_NEG) begin
         new_right = 1'b1;
      end else if (avg > OFF_NEG) begin
         new_right = 1'b0;
      end
   end

   // Output FSM
   state_e state_q, state_d;

   always_comb begin
      state_d = state_q;
      left_d  = left_q;
      right_d = right_q;
      int_d   = int_q;
      valid_d = 1'b0;
      case (state_q)
         FILL: begin
            if (win_done) begin
               state_d = RUN;
               left_d  = new_left;
               right_d = new_right;
               int_d   = new_int;
               valid_d = 1'b1;
            end
         end
         RUN: begin
            if (win_done) begin
               left_d  = new_left;
               right_d = new_right;
               int_d   = new_int;
               valid_d = 1'b1;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FILL;
         left_q  <= 1'b0;
         right_q <= 1'b0;
         int_q   <= 4'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         left_q  <= left_d;
         right_q <= right_d;
         int_q   <= int_d;
         valid_q <= valid_d;
      end
   end

   assign tilt_left      = left_q;
   assign tilt_right     = right_q;
   assign tilt_intensity = int_q;
   assign sample_valid   = valid_q;

endmodule
